// File: rtl/fifo_pkg.sv
// Shared FIFO package: default sample geometry and a width helper
// used by the FIFO, the write-side packer and the readout logic.
package fifo_pkg;

  localparam int SAMPLES_PER_WORD = 4;
  localparam int IN_WIDTH         = 12;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sample_packer_if.sv
// Sample-in / FIFO-write bundle of the packer.
// master = packer side, slave = source/FIFO side.
interface fifo_sample_packer_if
  import fifo_pkg::*;
#(
  parameter int pIN_WIDTH         = IN_WIDTH,
  parameter int pSAMPLES_PER_WORD = SAMPLES_PER_WORD,
  parameter int pCOUNT_WIDTH      = 16
);

  localparam int W  = pIN_WIDTH * pSAMPLES_PER_WORD;
  localparam int LW = clog2(pSAMPLES_PER_WORD) + 1;

  logic                    sample_valid;
  logic [pIN_WIDTH-1:0]    sample_data;
  logic                    flush;
  logic                    fifo_full;
  logic                    fifo_wen;
  logic [W-1:0]            fifo_wdata;
  logic [LW-1:0]           last_count;
  logic                    drop_error;
  logic [pCOUNT_WIDTH-1:0] drop_count;
  logic [pCOUNT_WIDTH-1:0] word_count;

  modport master (
    input  sample_valid, sample_data, flush, fifo_full,
    output fifo_wen, fifo_wdata, last_count,
    output drop_error, drop_count, word_count
  );

  modport slave (
    output sample_valid, sample_data, flush, fifo_full,
    input  fifo_wen, fifo_wdata, last_count,
    input  drop_error, drop_count, word_count
  );

endinterface

// File: rtl/fifo_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module fifo_sat_counter #(
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    clear_i,
  input  logic                    inc_i,
  output logic [pCOUNT_WIDTH-1:0] count_o
);

  logic [pCOUNT_WIDTH-1:0] cnt_q, cnt_d;

  // next count: step unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // count register, cleared synchronously
  always_ff @(posedge clk) begin
    if (clear_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_sample_packer.sv
// Packs narrow samples MS-slot-first into FIFO words; drops on full.
// Define FIFO_PACKER_STATS_EN to build the drop/word statistics counters.
module fifo_sample_packer
  import fifo_pkg::*;
#(
  parameter int pIN_WIDTH         = IN_WIDTH,
  parameter int pSAMPLES_PER_WORD = SAMPLES_PER_WORD,
  parameter int pCOUNT_WIDTH      = 16
) (
  input logic                  clk,
  input logic                  reset,
  fifo_sample_packer_if.master bus
);

  localparam int N  = pSAMPLES_PER_WORD;
  localparam int W  = pIN_WIDTH * N;
  localparam int IW = clog2(N);
  localparam int LW = IW + 1;

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sr_q, sr_d;
  logic          rdy_q, rdy_d;
  logic [W-1:0]  wdata_q, wdata_d;
  logic [LW-1:0] last_q, last_d;
  logic          derr_q, derr_d;

  logic [W-1:0]  sr_n;
  logic [LW-1:0] cnt;
  logic          emit;
  logic          drop;

  assign bus.fifo_wen = rdy_q & ~bus.fifo_full;
  assign drop         = rdy_q & bus.fifo_full;

  // slot insert, word completion / flush, drop flag
  always_comb begin
    sr_n = sr_q;
    cnt  = {1'b0, idx_q};
    if (bus.sample_valid) begin
      for (int s = 0; s < N; s++)
        if (idx_q == IW'(s))
          sr_n[W-1-s*pIN_WIDTH -: pIN_WIDTH] = bus.sample_data;
      cnt = {1'b0, idx_q} + LW'(1);
    end
    // a completing sample and a flush in one cycle still give one word
    emit = (cnt == LW'(N)) || (bus.flush && (cnt != '0));
    idx_d   = cnt[IW-1:0];
    sr_d    = sr_n;
    rdy_d   = 1'b0;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (emit) begin
      idx_d   = '0;
      sr_d    = '0;
      rdy_d   = 1'b1;
      wdata_d = sr_n;
      last_d  = cnt;
    end
    derr_d = derr_q | drop;
  end

  // packer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      sr_q    <= '0;
      rdy_q   <= 1'b0;
      wdata_q <= '0;
      last_q  <= '0;
      derr_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      rdy_q   <= rdy_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      derr_q  <= derr_d;
    end
  end

  assign bus.fifo_wdata = wdata_q;
  assign bus.last_count = last_q;
  assign bus.drop_error = derr_q;

`ifdef FIFO_PACKER_STATS_EN
  fifo_sat_counter #(.pCOUNT_WIDTH(pCOUNT_WIDTH)) u_drop_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (drop),
    .count_o (bus.drop_count)
  );

  fifo_sat_counter #(.pCOUNT_WIDTH(pCOUNT_WIDTH)) u_word_cnt (
    .clk     (clk),
    .clear_i (reset),
    .inc_i   (bus.fifo_wen),
    .count_o (bus.word_count)
  );
`else
  assign bus.drop_count = '0;
  assign bus.word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_sample_packer.sv
// Directed bench for fifo_sample_packer (N=4, 12-bit samples),
// plus a 2-bit-counter copy that sees the same stimulus.
module tb_fifo_sample_packer;

`ifdef FIFO_PACKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_sample_packer_if #(.pIN_WIDTH(12), .pSAMPLES_PER_WORD(4),
                          .pCOUNT_WIDTH(16)) b1 ();
  fifo_sample_packer_if #(.pIN_WIDTH(12), .pSAMPLES_PER_WORD(4),
                          .pCOUNT_WIDTH(2)) b2 ();

  fifo_sample_packer #(.pIN_WIDTH(12), .pSAMPLES_PER_WORD(4),
                       .pCOUNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  fifo_sample_packer #(.pIN_WIDTH(12), .pSAMPLES_PER_WORD(4),
                       .pCOUNT_WIDTH(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (b2)
  );

  assign b2.sample_valid = b1.sample_valid;
  assign b2.sample_data  = b1.sample_data;
  assign b2.flush        = b1.flush;
  assign b2.fifo_full    = b1.fifo_full;

  logic [47:0] wq[$];
  int          wc[$];

  always @(negedge clk)
    if (b1.fifo_wen) begin
      wq.push_back(b1.fifo_wdata);
      wc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [11:0] d, input logic fl);
    b1.sample_valid = 1'b1;
    b1.sample_data  = d;
    b1.flush        = fl;
    tick();
    b1.sample_valid = 1'b0;
    b1.flush        = 1'b0;
  endtask

  int n0;
  int s4;
  int s8;

  initial begin
    reset           = 1'b1;
    b1.sample_valid = 1'b0;
    b1.sample_data  = '0;
    b1.flush        = 1'b0;
    b1.fifo_full    = 1'b0;
    idle(3);
    @(negedge clk);
    chk("rst_wen",   64'(b1.fifo_wen),   64'd0);
    chk("rst_wdata", 64'(b1.fifo_wdata), 64'd0);
    chk("rst_last",  64'(b1.last_count), 64'd0);
    chk("rst_derr",  64'(b1.drop_error), 64'd0);
    chk("rst_dcnt",  64'(b1.drop_count), 64'd0);
    chk("rst_wcnt",  64'(b1.word_count), 64'd0);
    tick();
    reset = 1'b0;

    // 1: eight samples back to back
    n0 = wq.size();
    for (int i = 1; i <= 8; i++) begin
      push(12'(i), 1'b0);
      if (i == 4) s4 = cyc;
      if (i == 8) s8 = cyc;
    end
    idle(2);
    @(negedge clk);
    chk("t1_nwen",  64'(wq.size() - n0), 64'd2);
    chk("t1_word0", 64'(wq[n0]),     64'h001002003004);
    chk("t1_word1", 64'(wq[n0+1]),   64'h005006007008);
    chk("t1_lat0",  64'(wc[n0]),     64'(s4));
    chk("t1_lat1",  64'(wc[n0+1]),   64'(s8));
    chk("t1_space", 64'(wc[n0+1] - wc[n0]), 64'd4);
    chk("t1_wcnt",  64'(b1.word_count), STATS ? 64'd2 : 64'd0);
    chk("t1_last",  64'(b1.last_count), 64'd4);
    tick();

    // 2: partial word then flush
    n0 = wq.size();
    push(12'hAAA, 1'b0);
    push(12'hBBB, 1'b0);
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    idle(2);
    @(negedge clk);
    chk("t2_nwen", 64'(wq.size() - n0), 64'd1);
    chk("t2_word", 64'(wq[n0]), 64'hAAABBB000000);
    chk("t2_last", 64'(b1.last_count), 64'd2);
    tick();
    n0 = wq.size();
    for (int i = 1; i <= 4; i++) push(12'(i), 1'b0);
    idle(2);
    @(negedge clk);
    chk("t2_idx0", 64'(wq[n0]), 64'h001002003004);
    chk("t2_lst4", 64'(b1.last_count), 64'd4);
    tick();

    // 3: word completes while FIFO full
    n0 = wq.size();
    b1.fifo_full = 1'b1;
    for (int i = 1; i <= 4; i++) push(12'h100 + 12'(i), 1'b0);
    idle(1);
    b1.fifo_full = 1'b0;
    idle(1);
    @(negedge clk);
    chk("t3_nowen", 64'(wq.size() - n0), 64'd0);
    chk("t3_derr",  64'(b1.drop_error),  64'd1);
    chk("t3_dcnt",  64'(b1.drop_count),  STATS ? 64'd1 : 64'd0);
    tick();
    for (int i = 5; i <= 8; i++) push(12'h100 + 12'(i), 1'b0);
    idle(2);
    @(negedge clk);
    chk("t3_nwen", 64'(wq.size() - n0), 64'd1);
    chk("t3_word", 64'(wq[n0]), 64'h105106107108);
    chk("t3_derr2", 64'(b1.drop_error), 64'd1);
    chk("t3_wcnt", 64'(b1.word_count), STATS ? 64'd5 : 64'd0);
    tick();

    // 4: flush with the completing sample, then flush alone
    n0 = wq.size();
    push(12'h00A, 1'b0);
    push(12'h00B, 1'b0);
    push(12'h00C, 1'b0);
    push(12'h00D, 1'b1);
    idle(3);
    @(negedge clk);
    chk("t4_nwen", 64'(wq.size() - n0), 64'd1);
    chk("t4_word", 64'(wq[n0]), 64'h00A00B00C00D);
    chk("t4_last", 64'(b1.last_count), 64'd4);
    tick();
    n0 = wq.size();
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    idle(2);
    @(negedge clk);
    chk("t4_fl0", 64'(wq.size() - n0), 64'd0);
    chk("t4_lkeep", 64'(b1.last_count), 64'd4);
    chk("t4_wcnt", 64'(b1.word_count), STATS ? 64'd6 : 64'd0);
    tick();

    // 5: reset in the middle of a word
    n0 = wq.size();
    push(12'h0E1, 1'b0);
    push(12'h0E2, 1'b0);
    push(12'h0E3, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(3);
    @(negedge clk);
    chk("t5_nowen", 64'(wq.size() - n0), 64'd0);
    chk("t5_derr",  64'(b1.drop_error),  64'd0);
    chk("t5_last",  64'(b1.last_count),  64'd0);
    chk("t5_wcnt0", 64'(b1.word_count),  64'd0);
    tick();
    push(12'h111, 1'b0);
    push(12'h222, 1'b0);
    push(12'h333, 1'b0);
    push(12'h444, 1'b0);
    idle(2);
    @(negedge clk);
    chk("t5_nwen", 64'(wq.size() - n0), 64'd1);
    chk("t5_word", 64'(wq[n0]), 64'h111222333444);
    tick();

    // 6: five drops, 2-bit copy saturates
    n0 = wq.size();
    b1.fifo_full = 1'b1;
    for (int i = 0; i < 20; i++) push(12'(i), 1'b0);
    idle(2);
    b1.fifo_full = 1'b0;
    idle(1);
    @(negedge clk);
    chk("t6_nowen", 64'(wq.size() - n0), 64'd0);
    chk("t6_derr",  64'(b1.drop_error),  64'd1);
    chk("t6_dcnt",  64'(b1.drop_count),  STATS ? 64'd5 : 64'd0);
    chk("t6_sat",   64'(b2.drop_count),  STATS ? 64'd3 : 64'd0);
    chk("t6_satw",  64'(b2.word_count),  STATS ? 64'd1 : 64'd0);
    chk("t6_wcnt",  64'(b1.word_count),  STATS ? 64'd1 : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
